// File: rtl/jtgng_slotarb.sv
// jtgng_slotarb: H-locked time-slot arbiter sharing one ROM read port among
// four requesters (CPU, character, scroll, object).
//
// Each 8-pixel group is split into four slots selected by H[2:1]:
// 0 char, 1 scroll, 2 object, 3 CPU. During active video the slot owner wins
// if it is requesting; otherwise (and during all of vertical blank) the
// fixed order cpu > obj > scr > chr applies.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cen12              12 MHz enable; arbitration only on these cycles
//   H, LVBL            video timer horizontal count and vertical blank (low)
//   *_req / *_addr     level requests and their addresses
//   *_ok               one-clk pulse, dout valid for that requester
//   dout               last read data, held until the next read completes
//   mem_addr, mem_rd   memory request (mem_rd held until mem_ack)
//   mem_ack, mem_data  memory response
//   err                sticky watchdog flag
module jtgng_slotarb #(
  parameter int unsigned AW   = 17,
  parameter int unsigned DW   = 16,
  parameter logic [7:0]  TOUT = 8'd255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen12,
  input  logic [8:0]    H,
  input  logic          LVBL,
  input  logic          cpu_req,
  input  logic          chr_req,
  input  logic          scr_req,
  input  logic          obj_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [AW-1:0] chr_addr,
  input  logic [AW-1:0] scr_addr,
  input  logic [AW-1:0] obj_addr,
  output logic          cpu_ok,
  output logic          chr_ok,
  output logic          scr_ok,
  output logic          obj_ok,
  output logic [DW-1:0] dout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic          err
);

  localparam logic [1:0] IdCpu = 2'd0;
  localparam logic [1:0] IdChr = 2'd1;
  localparam logic [1:0] IdScr = 2'd2;
  localparam logic [1:0] IdObj = 2'd3;

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic          r_mem_rd, w_mem_rd_nxt;
  logic [DW-1:0] r_dout, w_dout_nxt;
  logic [3:0]    r_ok, w_ok_nxt;
  logic          r_err, w_err_nxt;
  logic [1:0]    r_id, w_id_nxt;
  logic [3:0]    r_mask, w_mask_nxt;
  logic [7:0]    r_wd, w_wd_nxt;

  logic [3:0]    w_req, w_elig;
  logic [1:0]    w_owner, w_win;
  logic [AW-1:0] w_win_addr;
  logic          w_grant, w_timeout;
  logic [3:0]    w_id_onehot;
  logic          w_unused_h;

  // Only the slot bits of H matter here.
  assign w_unused_h = ^{H[8:3], H[0]};

  assign w_req  = {obj_req, scr_req, chr_req, cpu_req};
  // The last served requester is masked through HOLD and the first IDLE clk
  // so a req that drops shortly after ok cannot be granted again.
  assign w_elig = w_req & ~r_mask;

  always_comb begin
    w_owner = IdCpu;
    unique case (H[2:1])
      2'd0:    w_owner = IdChr;
      2'd1:    w_owner = IdScr;
      2'd2:    w_owner = IdObj;
      default: w_owner = IdCpu;
    endcase
  end

  always_comb begin
    w_win = IdChr;
    if (LVBL && w_elig[w_owner]) w_win = w_owner;
    else if (w_elig[IdCpu])      w_win = IdCpu;
    else if (w_elig[IdObj])      w_win = IdObj;
    else if (w_elig[IdScr])      w_win = IdScr;
    else                         w_win = IdChr;
  end

  always_comb begin
    w_win_addr = cpu_addr;
    unique case (w_win)
      IdCpu:   w_win_addr = cpu_addr;
      IdChr:   w_win_addr = chr_addr;
      IdScr:   w_win_addr = scr_addr;
      default: w_win_addr = obj_addr;
    endcase
  end

  assign w_grant     = (r_state == StIdle) && cen12 && (|w_elig);
  // Ack has priority over the watchdog on the same cycle.
  assign w_timeout   = (r_state == StWait) && !mem_ack && ((r_wd + 8'd1) == TOUT);
  assign w_id_onehot = 4'b0001 << r_id;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_grant) w_state_nxt = StWait;
      StWait: begin
        if (mem_ack)        w_state_nxt = StHold;
        else if (w_timeout) w_state_nxt = StIdle;
      end
      StHold:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_mem_addr_nxt = r_mem_addr;
    w_mem_rd_nxt   = r_mem_rd;
    w_dout_nxt     = r_dout;
    w_ok_nxt       = 4'b0000;
    w_err_nxt      = r_err;
    w_id_nxt       = r_id;
    w_mask_nxt     = r_mask;
    w_wd_nxt       = r_wd;
    unique case (r_state)
      StIdle: begin
        w_mask_nxt = 4'b0000;
        if (w_grant) begin
          w_mem_addr_nxt = w_win_addr;
          w_mem_rd_nxt   = 1'b1;
          w_id_nxt       = w_win;
          w_wd_nxt       = 8'd0;
        end
      end
      StWait: begin
        if (mem_ack) begin
          w_dout_nxt   = mem_data;
          w_ok_nxt     = w_id_onehot;
          w_mem_rd_nxt = 1'b0;
          w_mask_nxt   = w_id_onehot;
        end else if (w_timeout) begin
          // No ok: the requester keeps req high and is re-arbitrated.
          w_mem_rd_nxt = 1'b0;
          w_err_nxt    = 1'b1;
        end else begin
          w_wd_nxt = r_wd + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_dout     <= '0;
      r_ok       <= 4'b0000;
      r_err      <= 1'b0;
      r_id       <= IdCpu;
      r_mask     <= 4'b0000;
      r_wd       <= 8'd0;
    end else begin
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_rd   <= w_mem_rd_nxt;
      r_dout     <= w_dout_nxt;
      r_ok       <= w_ok_nxt;
      r_err      <= w_err_nxt;
      r_id       <= w_id_nxt;
      r_mask     <= w_mask_nxt;
      r_wd       <= w_wd_nxt;
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_rd   = r_mem_rd;
  assign dout     = r_dout;
  assign err      = r_err;
  assign cpu_ok   = r_ok[IdCpu];
  assign chr_ok   = r_ok[IdChr];
  assign scr_ok   = r_ok[IdScr];
  assign obj_ok   = r_ok[IdObj];

endmodule

// File: tb/tb_jtgng_slotarb.sv
// Testbench for jtgng_slotarb: directed scenarios plus a randomized run, all
// checked every clk against a transaction-level reference model.
// Requester ids: 0 cpu, 1 chr, 2 scr, 3 obj.
module tb_jtgng_slotarb;
  localparam int AW   = 17;
  localparam int DW   = 16;
  localparam int TOUT = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen12 = 1'b0;
  logic [8:0]    H = 9'd0;
  logic          LVBL = 1'b1;
  logic [3:0]    b_req = 4'b0000;
  logic [AW-1:0] b_addr[4];
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_data = '0;

  logic          cpu_ok, chr_ok, scr_ok, obj_ok, mem_rd, err;
  logic [DW-1:0] dout;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  jtgng_slotarb #(.AW(AW), .DW(DW), .TOUT(8'd255)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen12    (cen12),
    .H        (H),
    .LVBL     (LVBL),
    .cpu_req  (b_req[0]),
    .chr_req  (b_req[1]),
    .scr_req  (b_req[2]),
    .obj_req  (b_req[3]),
    .cpu_addr (b_addr[0]),
    .chr_addr (b_addr[1]),
    .scr_addr (b_addr[2]),
    .obj_addr (b_addr[3]),
    .cpu_ok   (cpu_ok),
    .chr_ok   (chr_ok),
    .scr_ok   (scr_ok),
    .obj_ok   (obj_ok),
    .dout     (dout),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .err      (err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int owner_of[4] = '{1, 2, 3, 0};   // slot -> owner id
  int fallback[4] = '{0, 3, 2, 1};   // cpu > obj > scr > chr

  int            m_inflight;   // id being read, -1 when none
  int            m_wait;       // clks waited for the current read
  bit            m_settle;     // the one clk after data returned
  int            m_blocked;
  int            m_block_left;
  logic          exp_rd;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_dout;
  logic [3:0]    exp_ok;
  logic          exp_err;

  function automatic int pick(input logic [3:0] elig, input logic [1:0] slot, input logic lvbl);
    int own;
    own = owner_of[slot];
    if (lvbl && elig[own]) return own;
    for (int k = 0; k < 4; k++) if (elig[fallback[k]]) return fallback[k];
    return -1;
  endfunction

  task automatic model_reset();
    m_inflight = -1; m_wait = 0; m_settle = 0; m_blocked = -1; m_block_left = 0;
    exp_rd = 0; exp_addr = '0; exp_dout = '0; exp_ok = 4'b0000; exp_err = 0;
  endtask

  // One clock edge, using the inputs the DUT saw at that edge.
  task automatic model_edge();
    logic [3:0] elig;
    int w;
    exp_ok = 4'b0000;
    elig = b_req;
    if (m_block_left > 0) elig[m_blocked] = 1'b0;
    if (m_inflight >= 0) begin
      if (mem_ack) begin
        exp_dout = mem_data;
        exp_ok[m_inflight] = 1'b1;
        exp_rd = 0;
        m_blocked = m_inflight;
        m_block_left = 3;  // this edge, the HOLD edge, then one IDLE decision
        m_inflight = -1;
        m_settle = 1;
      end else begin
        m_wait++;
        if (m_wait == TOUT) begin
          exp_rd = 0;
          exp_err = 1;
          m_inflight = -1;
        end
      end
    end else if (m_settle) begin
      m_settle = 0;
    end else if (cen12 && elig != 4'b0000) begin
      w = pick(elig, H[2:1], LVBL);
      exp_rd = 1;
      exp_addr = b_addr[w];
      m_inflight = w;
      m_wait = 0;
    end
    if (m_block_left > 0) m_block_left--;
  endtask

  // ---------------- bench-side requesters and memory ----------------
  int            drop_cnt[4] = '{0, 0, 0, 0};
  int            drop_delay[4] = '{0, 0, 0, 0};
  int            ok_log[$];
  logic [DW-1:0] dout_log[$];
  logic [AW-1:0] grant_log[$];
  logic [DW-1:0] data_q[$];
  int            rd_rises = 0;
  logic          prev_rd = 0;
  int            rd_age = 0;
  int            ack_lat = 2;
  bit            rand_lat = 0;

  task automatic step();
    logic [3:0] okv;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    okv = {obj_ok, scr_ok, chr_ok, cpu_ok};
    check_eq("mem_rd", {31'd0, mem_rd}, {31'd0, exp_rd});
    if (exp_rd) check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
    check_eq("ok", {28'd0, okv}, {28'd0, exp_ok});
    check_eq("dout", 32'(dout), 32'(exp_dout));
    check_eq("err", {31'd0, err}, {31'd0, exp_err});
    if (mem_rd && !prev_rd) begin
      grant_log.push_back(mem_addr);
      rd_rises++;
    end
    prev_rd = mem_rd;
    for (int i = 0; i < 4; i++) begin
      if (okv[i]) begin
        ok_log.push_back(i);
        dout_log.push_back(dout);
        drop_cnt[i] = drop_delay[i] + 1;
      end
      if (drop_cnt[i] > 0) begin
        drop_cnt[i]--;
        if (drop_cnt[i] == 0) b_req[i] = 1'b0;
      end
    end
    if (mem_rd) begin
      rd_age++;
      if (rd_age == 1 && rand_lat) ack_lat = $urandom_range(1, 4);
      mem_ack = (ack_lat != 0) && (rd_age == ack_lat);
    end else begin
      rd_age = 0;
      mem_ack = 1'b0;
    end
    if (mem_ack && data_q.size() > 0) mem_data = data_q.pop_front();
    else mem_data = DW'($urandom);
  endtask

  task automatic pulse_cen(input logic [8:0] h);
    H = h;
    cen12 = 1'b1;
    step();
    cen12 = 1'b0;
  endtask

  task automatic clear_logs();
    ok_log.delete();
    dout_log.delete();
    grant_log.delete();
    rd_rises = 0;
  endtask

  int            exp_a[4] = '{1, 2, 3, 0};
  logic [DW-1:0] dat_a[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  int            n;

  initial begin
    for (int i = 0; i < 4; i++) b_addr[i] = '0;
    model_reset();
    repeat (2) step();
    check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    #3 rst_n = 1'b1;  // released away from any cen12 alignment

    // Slot ownership: all four requesting, one grant per slot.
    b_addr[0] = 17'h10000; b_addr[1] = 17'h00100;
    b_addr[2] = 17'h00200; b_addr[3] = 17'h00300;
    b_req = 4'b1111;
    foreach (dat_a[i]) data_q.push_back(dat_a[i]);
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      pulse_cen(9'h100 + 9'(2 * i));
      repeat (4) step();
    end
    check_eq("slot_count", ok_log.size(), 4);
    for (int i = 0; i < ok_log.size() && i < 4; i++) begin
      check_eq("slot_order", ok_log[i], exp_a[i]);
      check_eq("slot_dout", 32'(dout_log[i]), 32'(dat_a[i]));
    end

    // Spare slot reuse: only obj, granted in the chr and cpu slots.
    clear_logs();
    data_q.push_back(16'hA5A5); data_q.push_back(16'hA5A5);
    b_req = 4'b1000;
    pulse_cen(9'h100);
    repeat (4) step();
    b_req[3] = 1'b1;
    pulse_cen(9'h106);
    repeat (4) step();
    check_eq("spare_count", ok_log.size(), 2);
    for (int i = 0; i < ok_log.size() && i < 2; i++) begin
      check_eq("spare_id", ok_log[i], 3);
      check_eq("spare_dout", 32'(dout_log[i]), 32'h0000A5A5);
    end

    // Vertical blank: slot 0 belongs to chr, but cpu goes first.
    clear_logs();
    LVBL = 1'b0;
    b_addr[0] = 17'h1F000; b_addr[1] = 17'h00040;
    b_req = 4'b0011;
    pulse_cen(9'h100);
    repeat (4) step();
    pulse_cen(9'h100);
    repeat (4) step();
    LVBL = 1'b1;
    check_eq("vbl_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check_eq("vbl_addr0", 32'(grant_log[0]), 32'h1F000);
      check_eq("vbl_addr1", 32'(grant_log[1]), 32'h00040);
    end
    check_eq("vbl_oks", ok_log.size(), 2);
    if (ok_log.size() == 2) begin
      check_eq("vbl_first", ok_log[0], 0);
      check_eq("vbl_second", ok_log[1], 1);
    end

    // No double service: chr drops req one clk after its ok.
    clear_logs();
    ack_lat = 1;
    drop_delay[1] = 1;
    b_req = 4'b0010;
    cen12 = 1'b1;
    repeat (12) step();
    cen12 = 1'b0;
    check_eq("dbl_rd_rises", rd_rises, 1);
    check_eq("dbl_oks", ok_log.size(), 1);
    drop_delay[1] = 0;

    // Watchdog: no ack, mem_rd held 255 clk, then re-issue and complete.
    clear_logs();
    check_eq("wd_err_before", {31'd0, err}, 32'd0);
    ack_lat = 0;
    b_req = 4'b0001;
    pulse_cen(H);
    n = 0;
    while (mem_rd && n < 400) begin
      n++;
      step();
    end
    check_eq("wd_len", n, 255);
    check_eq("wd_err", {31'd0, err}, 32'd1);
    check_eq("wd_no_ok", ok_log.size(), 0);
    ack_lat = 2;
    pulse_cen(H);
    repeat (4) step();
    check_eq("wd_retry_ok", ok_log.size(), 1);
    check_eq("wd_err_sticky", {31'd0, err}, 32'd1);

    // Reset in the middle of a read.
    clear_logs();
    ack_lat = 0;
    b_req = 4'b0001;
    pulse_cen(H);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_rd", {31'd0, mem_rd}, 32'd0);
    check_eq("rstmid_dout", 32'(dout), 32'd0);
    check_eq("rstmid_err", {31'd0, err}, 32'd0);
    model_reset();
    b_req = 4'b0000;
    repeat (2) step();
    #3 rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_data = 16'hBEEF;
    step();
    step();
    check_eq("late_ack_no_ok", ok_log.size(), 0);

    // Randomized traffic.
    rand_lat = 1;
    for (int c = 0; c < 3000; c++) begin
      cen12 = ($urandom_range(0, 2) != 0);
      if (cen12) H = H + 9'd1;
      if ($urandom_range(0, 249) == 0) LVBL = ~LVBL;
      for (int i = 0; i < 4; i++) begin
        if (!b_req[i] && drop_cnt[i] == 0 && $urandom_range(0, 5) == 0) begin
          b_req[i] = 1'b1;
          b_addr[i] = AW'($urandom);
          drop_delay[i] = $urandom_range(0, 2);
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
